// File: rtl/renode_bus_dispatcher.sv
// renode_bus_dispatcher: buffers Renode-style (action, address, data) messages
// in a small command FIFO and executes them one at a time, in order. Bus
// accesses go to one of ChannelCount controller ports with a per-access
// timeout, ticks count down in clock cycles, and reset commands pulse
// periph_rst_n. Every accepted command yields exactly one response.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. msg_in_valid/msg_in_ready carry commands into the FIFO;
// rsp_valid/rsp_ready carry responses out, and rsp_* fields are held stable
// while rsp_valid is high and rsp_ready is low.
module renode_bus_dispatcher #(
  parameter int AddressWidth         = 32,
  parameter int DataWidth            = 32,
  parameter int ChannelCount         = 2,
  parameter int ChannelSelectLsb     = 28,
  parameter int BusControllerTimeout = 100,
  parameter int CmdFifoDepth         = 4,
  parameter int ResetCycles          = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 msg_in_valid,
  output logic                                 msg_in_ready,
  input  logic [2:0]                           msg_in_action,
  input  logic [AddressWidth-1:0]              msg_in_address,
  input  logic [DataWidth-1:0]                 msg_in_data,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [2:0]                           rsp_action,
  output logic [AddressWidth-1:0]              rsp_address,
  output logic [DataWidth-1:0]                 rsp_data,
  output logic [ChannelCount-1:0]              bus_req,
  output logic [ChannelCount-1:0]              bus_we,
  output logic [ChannelCount*AddressWidth-1:0] bus_addr,
  output logic [ChannelCount*DataWidth-1:0]    bus_wdata,
  input  logic [ChannelCount-1:0]              bus_ack,
  input  logic [ChannelCount-1:0]              bus_err,
  input  logic [ChannelCount*DataWidth-1:0]    bus_rdata,
  output logic                                 periph_rst_n,
  output logic                                 busy,
  output logic [2:0]                           dbg_state
);

  localparam int SelW  = (ChannelCount > 1) ? $clog2(ChannelCount) : 1;
  localparam int PtrW  = $clog2(CmdFifoDepth);
  localparam int TmoW  = $clog2(BusControllerTimeout + 1);
  localparam int RstW  = $clog2(ResetCycles + 1);
  localparam int FifoW = 3 + AddressWidth + DataWidth;

  // Command actions
  localparam logic [2:0] A_RESET = 3'd0;
  localparam logic [2:0] A_TICK  = 3'd1;
  localparam logic [2:0] A_WRITE = 3'd2;
  localparam logic [2:0] A_READ  = 3'd3;

  // Response actions
  localparam logic [2:0] R_OK    = 3'd0;
  localparam logic [2:0] R_RDATA = 3'd1;
  localparam logic [2:0] R_ERR   = 3'd2;
  localparam logic [2:0] R_TICK  = 3'd3;
  localparam logic [2:0] R_UNSUP = 3'd4;

  // FSM states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_TICK    = 3'd2;
  localparam logic [2:0] S_RESET   = 3'd3;
  localparam logic [2:0] S_RESPOND = 3'd4;

  logic [2:0] state;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [FifoW-1:0] fifo_mem [CmdFifoDepth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    fifo_count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (fifo_count == (PtrW+1)'(CmdFifoDepth));
  assign empty = (fifo_count == '0);
  // ready depends only on the registered count, so a full FIFO never accepts
  // a push even in a cycle where the FSM pops; it reopens one cycle later.
  assign push  = msg_in_valid && !full;
  assign pop   = (state == S_IDLE) && !empty;

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {msg_in_action, msg_in_address, msg_in_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head-of-queue decode
  logic [FifoW-1:0]        head;
  logic [2:0]              head_action;
  logic [AddressWidth-1:0] head_address;
  logic [DataWidth-1:0]    head_data;
  logic [SelW-1:0]         head_sel;
  logic [AddressWidth-1:0] head_upper;
  logic                    head_in_range;

  assign head         = fifo_mem[rd_ptr];
  assign head_action  = head[FifoW-1 -: 3];
  assign head_address = head[DataWidth +: AddressWidth];
  assign head_data    = head[DataWidth-1:0];
  assign head_sel     = head_address[ChannelSelectLsb +: SelW];
  // Every address bit from the select field upward must name an existing
  // channel; stray higher bits are a decode error, not an alias.
  assign head_upper    = head_address >> ChannelSelectLsb;
  assign head_in_range = (head_upper < AddressWidth'(ChannelCount));

  // ---------------------------------------------------------------------------
  // Command execution
  // ---------------------------------------------------------------------------
  logic [AddressWidth-1:0] cmd_address;
  logic [DataWidth-1:0]    cmd_wdata;
  logic [SelW-1:0]         cmd_sel;
  logic                    cmd_we;
  logic [TmoW-1:0]         tmo_cnt;
  logic [RstW-1:0]         rst_cnt;
  logic [DataWidth-1:0]    tick_cnt;
  logic [2:0]              rsp_action_q;
  logic [AddressWidth-1:0] rsp_address_q;
  logic [DataWidth-1:0]    rsp_data_q;

  logic                    sel_ack;
  logic                    sel_err;
  logic [DataWidth-1:0]    sel_rdata;

  // Pick out the completion signals of the channel the current access targets
  always_comb begin
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int c = 0; c < ChannelCount; c++) begin
      if (cmd_sel == SelW'(c)) begin
        sel_ack   = bus_ack[c];
        sel_err   = bus_err[c];
        sel_rdata = bus_rdata[c*DataWidth +: DataWidth];
      end
    end
  end

  // Main sequencer: pop, execute, respond, one command at a time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cmd_address   <= '0;
      cmd_wdata     <= '0;
      cmd_sel       <= '0;
      cmd_we        <= 1'b0;
      tmo_cnt       <= '0;
      rst_cnt       <= '0;
      tick_cnt      <= '0;
      rsp_action_q  <= '0;
      rsp_address_q <= '0;
      rsp_data_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            cmd_address   <= head_address;
            cmd_wdata     <= head_data;
            cmd_sel       <= head_sel;
            cmd_we        <= (head_action == A_WRITE);
            tmo_cnt       <= '0;
            rst_cnt       <= '0;
            rsp_address_q <= head_address;
            rsp_data_q    <= '0;
            case (head_action)
              A_RESET: state <= S_RESET;
              A_TICK: begin
                if (head_data == '0) begin
                  rsp_action_q <= R_TICK;
                  state        <= S_RESPOND;
                end else begin
                  tick_cnt <= head_data;
                  state    <= S_TICK;
                end
              end
              A_WRITE, A_READ: begin
                if (head_in_range) begin
                  state <= S_ACCESS;
                end else begin
                  rsp_action_q <= R_ERR;
                  state        <= S_RESPOND;
                end
              end
              default: begin
                rsp_action_q <= R_UNSUP;
                state        <= S_RESPOND;
              end
            endcase
          end
        end

        S_ACCESS: begin
          // An ack in the final timeout cycle still completes the access.
          if (sel_ack) begin
            if (sel_err) begin
              rsp_action_q <= R_ERR;
            end else if (cmd_we) begin
              rsp_action_q <= R_OK;
            end else begin
              rsp_action_q <= R_RDATA;
              rsp_data_q   <= sel_rdata;
            end
            state <= S_RESPOND;
          end else if (tmo_cnt == TmoW'(BusControllerTimeout - 1)) begin
            rsp_action_q <= R_ERR;
            state        <= S_RESPOND;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_TICK: begin
          tick_cnt <= tick_cnt - 1'b1;
          if (tick_cnt == DataWidth'(1)) begin
            rsp_action_q <= R_TICK;
            state        <= S_RESPOND;
          end
        end

        S_RESET: begin
          if (rst_cnt == RstW'(ResetCycles - 1)) begin
            rsp_action_q <= R_OK;
            state        <= S_RESPOND;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_RESPOND: begin
          if (rsp_ready) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Drive only the selected channel while an access is in flight
  always_comb begin
    bus_req   = '0;
    bus_we    = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    for (int c = 0; c < ChannelCount; c++) begin
      if ((state == S_ACCESS) && (cmd_sel == SelW'(c))) begin
        bus_req[c]                             = 1'b1;
        bus_we[c]                              = cmd_we;
        bus_addr[c*AddressWidth +: AddressWidth] = cmd_address;
        bus_wdata[c*DataWidth +: DataWidth]      = cmd_wdata;
      end
    end
  end

  assign msg_in_ready = !full;
  assign rsp_valid    = (state == S_RESPOND);
  assign rsp_action   = rsp_action_q;
  assign rsp_address  = rsp_address_q;
  assign rsp_data     = rsp_data_q;
  assign periph_rst_n = (state != S_RESET);
  assign busy         = (state != S_IDLE) || !empty;
  assign dbg_state    = state;

endmodule

// File: tb/tb_renode_bus_dispatcher.sv
// Directed + randomized bench for renode_bus_dispatcher. Expected responses
// come from a command-level model of the dispatcher's rules and a scoreboard
// queue; a behavioural bus responder acts as the controllers on each channel.
module tb_renode_bus_dispatcher;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CC  = 2;
  localparam int TMO = 100;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  logic              msg_in_valid;
  logic              msg_in_ready;
  logic [2:0]        msg_in_action;
  logic [AW-1:0]     msg_in_address;
  logic [DW-1:0]     msg_in_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_action;
  logic [AW-1:0]     rsp_address;
  logic [DW-1:0]     rsp_data;
  logic [CC-1:0]     bus_req;
  logic [CC-1:0]     bus_we;
  logic [CC*AW-1:0]  bus_addr;
  logic [CC*DW-1:0]  bus_wdata;
  logic [CC-1:0]     bus_ack;
  logic [CC-1:0]     bus_err;
  logic [CC*DW-1:0]  bus_rdata;
  logic              periph_rst_n;
  logic              busy;
  logic [2:0]        dbg_state;

  renode_bus_dispatcher dut (
    .clk(clk), .rst_n(rst_n),
    .msg_in_valid(msg_in_valid), .msg_in_ready(msg_in_ready),
    .msg_in_action(msg_in_action), .msg_in_address(msg_in_address),
    .msg_in_data(msg_in_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_action(rsp_action),
    .rsp_address(rsp_address), .rsp_data(rsp_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata), .periph_rst_n(periph_rst_n), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  int            ack_after [CC];   // req cycle on which the channel acks, 0 = never
  logic          cfg_err   [CC];
  logic [DW-1:0] cfg_rdata [CC];
  bit            noise_en;

  int            run        [CC];
  int            last_len   [CC];
  int            total_req  [CC];
  logic [AW-1:0] last_addr  [CC];
  logic [DW-1:0] last_wdata [CC];
  logic          last_we    [CC];
  int            prst_run;
  int            prst_len;
  int            last_wait;

  logic [66:0]   exp_q [$];

  logic [2:0]    bb_a  [5];
  logic [AW-1:0] bb_ad [5];
  logic [DW-1:0] bb_d  [5];

  // ---------------------------------------------------------------------------
  // Reference model: response for one command, given the responder setup
  // ---------------------------------------------------------------------------
  function automatic logic [66:0] model(logic [2:0] a, logic [AW-1:0] ad, logic [DW-1:0] d);
    int up;
    up = int'(ad[AW-1:28]);
    case (a)
      3'd0: return {3'd0, ad, 32'd0};
      3'd1: return {3'd3, ad, 32'd0};
      3'd2, 3'd3: begin
        if (up >= CC) return {3'd2, ad, 32'd0};
        if (ack_after[up] == 0 || ack_after[up] > TMO || cfg_err[up]) return {3'd2, ad, 32'd0};
        if (a == 3'd2) return {3'd0, ad, 32'd0};
        return {3'd1, ad, cfg_rdata[up]};
      end
      default: return {3'd4, ad, 32'd0 & d};
    endcase
  endfunction

  // Number of bus_req cycles a command should produce
  function automatic int exp_req(logic [2:0] a, logic [AW-1:0] ad);
    int up;
    up = int'(ad[AW-1:28]);
    if ((a != 3'd2 && a != 3'd3) || up >= CC) return 0;
    if (ack_after[up] == 0 || ack_after[up] > TMO) return TMO;
    return ack_after[up];
  endfunction

  function automatic int req_sum();
    int s;
    s = 0;
    for (int c = 0; c < CC; c++) s += total_req[c];
    return s;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic push_cmd(logic [2:0] a, logic [AW-1:0] ad, logic [DW-1:0] d);
    int n;
    exp_q.push_back(model(a, ad, d));
    msg_in_action  = a;
    msg_in_address = ad;
    msg_in_data    = d;
    msg_in_valid   = 1'b1;
    n = 0;
    while (!msg_in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", msg_in_ready, 1);
    @(negedge clk);
    msg_in_valid = 1'b0;
  endtask

  task automatic get_rsp(string tag, int hold);
    int n;
    logic [66:0] e;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 67'bx;
    chk({tag, "_valid"}, rsp_valid, 1);
    chk(tag, {rsp_action, rsp_address, rsp_data}, e);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Bus responder and monitors
  // ---------------------------------------------------------------------------
  initial begin
    bus_ack   = '0;
    bus_err   = '0;
    bus_rdata = '0;
    prst_run  = 0;
    prst_len  = 0;
    for (int c = 0; c < CC; c++) begin
      run[c] = 0; last_len[c] = 0; total_req[c] = 0;
      last_addr[c] = '0; last_wdata[c] = '0; last_we[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < CC; c++) begin
        if (bus_req[c]) begin
          run[c]++;
          total_req[c]++;
          last_addr[c]  = bus_addr[c*AW +: AW];
          last_wdata[c] = bus_wdata[c*DW +: DW];
          last_we[c]    = bus_we[c];
          bus_ack[c]    = (run[c] == ack_after[c]);
          bus_err[c]    = cfg_err[c];
          bus_rdata[c*DW +: DW] = cfg_rdata[c];
        end else begin
          if (run[c] != 0) last_len[c] = run[c];
          run[c] = 0;
          if (noise_en && (bus_req != '0)) begin
            bus_ack[c] = 1'($urandom_range(0, 1));
            bus_err[c] = 1'($urandom_range(0, 1));
            bus_rdata[c*DW +: DW] = $urandom;
          end else begin
            bus_ack[c] = 1'b0;
            bus_err[c] = 1'b0;
          end
        end
      end
      if (!periph_rst_n) prst_run++;
      else if (prst_run != 0) begin
        prst_len = prst_run;
        prst_run = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int s0;
    int n;
    int stale;
    int r;
    int el;
    logic [2:0]    a;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;

    msg_in_valid = 1'b0; msg_in_action = '0; msg_in_address = '0; msg_in_data = '0;
    rsp_ready = 1'b0; noise_en = 1'b0;
    for (int c = 0; c < CC; c++) begin
      ack_after[c] = 1; cfg_err[c] = 1'b0; cfg_rdata[c] = '0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", msg_in_ready, 1);
    chk("rst_periph", periph_rst_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_fields", {rsp_action, rsp_address, rsp_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write to channel 1, ack on the third request cycle
    ack_after[1] = 3;
    s0 = total_req[0];
    push_cmd(3'd2, 32'h1000_0004, 32'hDEAD_BEEF);
    get_rsp("wr_rsp", 0);
    chk("wr_latency", last_wait, 4);
    chk("wr_req_len", last_len[1], 3);
    chk("wr_wdata", last_wdata[1], 32'hDEAD_BEEF);
    chk("wr_addr", last_addr[1], 32'h1000_0004);
    chk("wr_we", last_we[1], 1);
    chk("wr_ch0_idle", total_req[0] - s0, 0);

    // Read from channel 0
    ack_after[0] = 1; cfg_rdata[0] = 32'h1234_5678;
    push_cmd(3'd3, 32'h0000_0010, 32'h0);
    get_rsp("rd_rsp", 0);
    chk("rd_req_len", last_len[0], 1);
    chk("rd_we", last_we[0], 0);

    // Out-of-range channel: immediate error, no bus activity
    s0 = req_sum();
    push_cmd(3'd3, 32'h2000_0000, 32'h0);
    get_rsp("oor_rsp", 0);
    chk("oor_latency", last_wait, 1);
    chk("oor_no_req", req_sum() - s0, 0);

    // Timeouts: never ack, ack on the last cycle, ack one cycle too late
    ack_after[0] = 0;
    push_cmd(3'd3, 32'h0000_0020, 32'h0);
    get_rsp("tmo_rsp", 0);
    chk("tmo_req_len", last_len[0], TMO);
    ack_after[0] = TMO; cfg_rdata[0] = 32'hA5A5_0001;
    push_cmd(3'd3, 32'h0000_0024, 32'h0);
    get_rsp("tmo_edge_rsp", 0);
    chk("tmo_edge_len", last_len[0], TMO);
    ack_after[0] = TMO + 1;
    push_cmd(3'd2, 32'h0000_0028, 32'h55);
    get_rsp("tmo_late_rsp", 0);
    chk("tmo_late_len", last_len[0], TMO);

    // Back-to-back pushes with responses held off
    ack_after[0] = 2; ack_after[1] = 1; cfg_rdata[1] = 32'hCAFE_F00D;
    bb_a[0] = 3'd1; bb_ad[0] = 32'h0000_0040; bb_d[0] = 32'd3;
    bb_a[1] = 3'd2; bb_ad[1] = 32'h0000_0100; bb_d[1] = 32'h1111_2222;
    bb_a[2] = 3'd3; bb_ad[2] = 32'h1000_0200; bb_d[2] = 32'h0;
    bb_a[3] = 3'd5; bb_ad[3] = 32'h0000_0077; bb_d[3] = 32'h9;
    bb_a[4] = 3'd1; bb_ad[4] = 32'h0000_0088; bb_d[4] = 32'd0;
    for (int i = 0; i < 5; i++) begin
      msg_in_action = bb_a[i]; msg_in_address = bb_ad[i]; msg_in_data = bb_d[i];
      msg_in_valid = 1'b1;
      exp_q.push_back(model(bb_a[i], bb_ad[i], bb_d[i]));
      chk($sformatf("b2b_ready%0d", i), msg_in_ready, 1);
      @(negedge clk);
    end
    msg_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_full", msg_in_ready, 0);
    get_rsp("b2b_rsp0", 0);
    push_cmd(3'd0, 32'h0000_0099, 32'h0);
    for (int i = 1; i < 6; i++) get_rsp($sformatf("b2b_rsp%0d", i), 1);

    // Tick timing and peripheral reset
    push_cmd(3'd1, 32'h0000_0044, 32'd10);
    get_rsp("tick10_rsp", 0);
    chk("tick10_latency", last_wait, 11);
    push_cmd(3'd1, 32'h0000_0048, 32'd0);
    get_rsp("tick0_rsp", 0);
    chk("tick0_latency", last_wait, 1);
    push_cmd(3'd0, 32'h0000_0055, 32'h0);
    push_cmd(3'd1, 32'h0000_0056, 32'd2);
    get_rsp("prst_rsp", 0);
    chk("prst_latency", last_wait, 4);
    chk("prst_len", prst_len, 4);
    get_rsp("prst_queued_rsp", 0);

    // Reset in the middle of an access
    ack_after[1] = 0;
    push_cmd(3'd2, 32'h1000_0008, 32'h1);
    push_cmd(3'd1, 32'h0000_0060, 32'd5);
    n = 0;
    while (!bus_req[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_req_seen", bus_req[1], 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_bus_req", bus_req, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", msg_in_ready, 1);
    chk("mid_periph", periph_rst_n, 1);
    rst_n = 1'b1;
    exp_q.delete();
    s0 = req_sum();
    stale = 0;
    rsp_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    rsp_ready = 1'b0;
    chk("mid_no_stale_rsp", stale, 0);
    chk("mid_no_stale_req", req_sum() - s0, 0);
    ack_after[1] = 2;
    push_cmd(3'd2, 32'h1000_000C, 32'h7777);
    get_rsp("mid_after_rsp", 0);

    // Randomized commands with ack noise on idle channels
    noise_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      for (int c = 0; c < CC; c++) begin
        ack_after[c] = $urandom_range(0, 7);
        cfg_err[c]   = ($urandom_range(0, 3) == 0);
        cfg_rdata[c] = $urandom;
      end
      r = $urandom_range(0, 9);
      if (r <= 5)      a = 3'($urandom_range(2, 3));
      else if (r == 7) a = 3'd0;
      else if (r == 8) a = 3'($urandom_range(4, 7));
      else             a = 3'd1;
      ad = {4'($urandom_range(0, 2)), 28'($urandom)};
      d  = (a == 3'd1) ? DW'($urandom_range(0, 15)) : DW'($urandom);
      el = exp_req(a, ad);
      s0 = req_sum();
      push_cmd(a, ad, d);
      get_rsp($sformatf("rnd%0d_rsp", i), $urandom_range(0, 3));
      chk($sformatf("rnd%0d_req", i), req_sum() - s0, el);
    end
    noise_en = 1'b0;

    repeat (2) @(negedge clk);
    chk("end_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
